// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: funct codes, FSM states, iteration count.
package muldiv_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  localparam int unsigned MULDIV_ITERS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Signed MULT/DIV support: operand magnitudes at acceptance and result negation at the final edge.
module muldiv_sign_fix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 i_signed,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic [WIDTH-1:0]     o_mag_a,
  output logic [WIDTH-1:0]     o_mag_b,
  output logic                 o_neg_q,
  output logic                 o_neg_r,
  input  logic                 i_neg_q,
  input  logic                 i_neg_r,
  input  logic [2*WIDTH-1:0]   i_prod,
  input  logic [WIDTH-1:0]     i_quo,
  input  logic [WIDTH-1:0]     i_rem,
  output logic [2*WIDTH-1:0]   o_prod,
  output logic [WIDTH-1:0]     o_quo,
  output logic [WIDTH-1:0]     o_rem
);

  logic w_a_neg;
  logic w_b_neg;

  always_comb begin
    w_a_neg = i_signed & i_a[WIDTH-1];
    w_b_neg = i_signed & i_b[WIDTH-1];
    o_mag_a = w_a_neg ? (~i_a + 1'b1) : i_a;
    o_mag_b = w_b_neg ? (~i_b + 1'b1) : i_b;
    // A zero divisor keeps the all-ones quotient, so the sign flip is suppressed there
    o_neg_q = (w_a_neg ^ w_b_neg) & (i_b != '0);
    o_neg_r = w_a_neg;
  end

  always_comb begin
    o_prod = i_neg_q ? (~i_prod + 1'b1) : i_prod;
    o_quo  = i_neg_q ? (~i_quo + 1'b1) : i_quo;
    o_rem  = i_neg_r ? (~i_rem + 1'b1) : i_rem;
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32-cycle multiply/divide unit owning HI/LO, with MTHI/MTLO writes and MFHI/MFLO reads.
// Signed MULT/DIV are built only when MULDIV_SIGNED_EN is defined.
module mul_div_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] rsData_i,
  input  logic [WIDTH-1:0] rtData_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] result_o
);

  localparam logic [5:0] CNT_LAST = 6'(MULDIV_ITERS - 1);

  muldiv_state_t        r_state;
  muldiv_state_t        w_state_nx;
  logic [5:0]           r_cnt;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [2*WIDTH-1:0]   r_work;
  logic [WIDTH-1:0]     r_opnd;

  logic                 w_dec_mul;
  logic                 w_dec_div;
  logic                 w_can_accept;
  logic                 w_acc_mul;
  logic                 w_acc_div;
  logic                 w_acc_mthi;
  logic                 w_acc_mtlo;
  logic                 w_iter;
  logic                 w_last;

  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_nx;
  logic [WIDTH:0]       w_div_sh;
  logic                 w_div_ge;
  logic [WIDTH-1:0]     w_div_diff;
  logic [2*WIDTH-1:0]   w_div_nx;
  logic [2*WIDTH-1:0]   w_prod_fix;
  logic [WIDTH-1:0]     w_quo_fix;
  logic [WIDTH-1:0]     w_rem_fix;

`ifdef MULDIV_SIGNED_EN
  logic                 w_dec_signed;
  logic                 w_neg_q_in;
  logic                 w_neg_r_in;
  logic                 r_neg_q;
  logic                 r_neg_r;
`endif

  always_comb begin
    w_dec_mul = (funct_i == FUNCT_MULTU);
    w_dec_div = (funct_i == FUNCT_DIVU);
`ifdef MULDIV_SIGNED_EN
    w_dec_signed = (funct_i == FUNCT_MULT) || (funct_i == FUNCT_DIV);
    w_dec_mul    = w_dec_mul | (funct_i == FUNCT_MULT);
    w_dec_div    = w_dec_div | (funct_i == FUNCT_DIV);
`endif
  end

  always_comb begin
    w_can_accept = start_i & ((r_state == IDLE) | (r_state == DONE));
    w_acc_mul    = w_can_accept & w_dec_mul;
    w_acc_div    = w_can_accept & w_dec_div;
    w_acc_mthi   = w_can_accept & (funct_i == FUNCT_MTHI);
    w_acc_mtlo   = w_can_accept & (funct_i == FUNCT_MTLO);
    w_iter       = (r_state == MUL) | (r_state == DIV);
    w_last       = w_iter & (r_cnt == CNT_LAST);
  end

  // Multiply keeps {partial, multiplier} in r_work; divide keeps {remainder, dividend/quotient}
  always_comb begin
    w_mul_sum  = {1'b0, r_work[2*WIDTH-1:WIDTH]} + (r_work[0] ? {1'b0, r_opnd} : '0);
    w_mul_nx   = {w_mul_sum, r_work[WIDTH-1:1]};
    w_div_sh   = {r_work[2*WIDTH-1:WIDTH], r_work[WIDTH-1]};
    w_div_ge   = (w_div_sh >= {1'b0, r_opnd});
    w_div_diff = w_div_sh[WIDTH-1:0] - r_opnd;
    w_div_nx   = w_div_ge ? {w_div_diff, r_work[WIDTH-2:0], 1'b1}
                          : {w_div_sh[WIDTH-1:0], r_work[WIDTH-2:0], 1'b0};
  end

`ifdef MULDIV_SIGNED_EN
  muldiv_sign_fix #(
    .WIDTH (WIDTH)
  ) u_sign_fix (
    .i_signed (w_dec_signed),
    .i_a      (rsData_i),
    .i_b      (rtData_i),
    .o_mag_a  (w_mag_a),
    .o_mag_b  (w_mag_b),
    .o_neg_q  (w_neg_q_in),
    .o_neg_r  (w_neg_r_in),
    .i_neg_q  (r_neg_q),
    .i_neg_r  (r_neg_r),
    .i_prod   (w_mul_nx),
    .i_quo    (w_div_nx[WIDTH-1:0]),
    .i_rem    (w_div_nx[2*WIDTH-1:WIDTH]),
    .o_prod   (w_prod_fix),
    .o_quo    (w_quo_fix),
    .o_rem    (w_rem_fix)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_acc_mul || w_acc_div) begin
      r_neg_q <= w_neg_q_in;
      r_neg_r <= w_neg_r_in;
    end
  end
`else
  assign w_mag_a    = rsData_i;
  assign w_mag_b    = rtData_i;
  assign w_prod_fix = w_mul_nx;
  assign w_quo_fix  = w_div_nx[WIDTH-1:0];
  assign w_rem_fix  = w_div_nx[2*WIDTH-1:WIDTH];
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE, DONE: begin
        w_state_nx = IDLE;
        if (w_acc_mul) begin
          w_state_nx = MUL;
        end else if (w_acc_div) begin
          w_state_nx = DIV;
        end
      end
      MUL, DIV: begin
        if (w_last) begin
          w_state_nx = DONE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_work <= '0;
      r_opnd <= '0;
    end else if (w_can_accept) begin
      r_cnt <= '0;
      if (w_acc_mthi) begin
        r_hi <= rsData_i;
      end
      if (w_acc_mtlo) begin
        r_lo <= rsData_i;
      end
      if (w_acc_mul) begin
        r_work <= {{WIDTH{1'b0}}, w_mag_b};
        r_opnd <= w_mag_a;
      end else if (w_acc_div) begin
        r_work <= {{WIDTH{1'b0}}, w_mag_a};
        r_opnd <= w_mag_b;
      end
    end else if (w_iter) begin
      r_work <= (r_state == DIV) ? w_div_nx : w_mul_nx;
      if (w_last) begin
        r_cnt <= '0;
        if (r_state == DIV) begin
          r_lo <= w_quo_fix;
          r_hi <= w_rem_fix;
        end else begin
          {r_hi, r_lo} <= w_prod_fix;
        end
      end else begin
        r_cnt <= r_cnt + 6'd1;
      end
    end
  end

  always_comb begin
    busy_o = (r_state == MUL) | (r_state == DIV);
    done_o = (r_state == DONE);
    hi_o   = r_hi;
    lo_o   = r_lo;
    if (funct_i == FUNCT_MFHI) begin
      result_o = r_hi;
    end else if (funct_i == FUNCT_MFLO) begin
      result_o = r_lo;
    end else begin
      result_o = '0;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: vector table plus scoreboard, with signed vectors under MULDIV_SIGNED_EN.
module tb_mul_div_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [5:0]  funct_i;
  logic [31:0] rsData_i;
  logic [31:0] rtData_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [31:0] result_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  typedef struct {
    string       name;
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[$];
  exp_t mon_e;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .funct_i  (funct_i),
    .rsData_i (rsData_i),
    .rtData_i (rtData_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .hi_o     (hi_o),
    .lo_o     (lo_o),
    .result_o (result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Scoreboard: every done_o pulse must match the oldest pending expectation
  always @(posedge clk_i) begin
    #1;
    if (done_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done_o=1 expected no pending result");
      end else begin
        mon_e = exp_q.pop_front();
        chk({mon_e.name, "_hi"}, hi_o, mon_e.hi);
        chk({mon_e.name, "_lo"}, lo_o, mon_e.lo);
      end
    end
  end

  task automatic wait_done(input string nm, output int nbusy);
    bit ok;
    nbusy = 0;
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (done_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (busy_o === 1'b1) nbusy++;
      step();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done_o within 40 cycles expected done_o", nm);
    end else begin
      chk({nm, "_busy_in_done"}, 32'(busy_o), 32'd0);
    end
  endtask

  task automatic run_op(input string nm, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int nbusy;
    exp_q.push_back('{nm, ehi, elo});
    start_i = 1'b1; funct_i = f; rsData_i = a; rtData_i = b;
    step();
    start_i = 1'b0; funct_i = 6'h00;
    wait_done(nm, nbusy);
    chk({nm, "_busy_cycles"}, 32'(nbusy), 32'd32);
    step();
    chk({nm, "_done_1cyc"}, 32'(done_o), 32'd0);
  endtask

  function automatic void add_model(input string nm, input logic [5:0] f,
                                    input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    vec_t v;
    v.name = nm; v.f = f; v.a = a; v.b = b;
    if (f == 6'h19) begin
      p = 64'(a) * 64'(b);
      v.hi = p[63:32];
      v.lo = p[31:0];
    end else if (b == 32'd0) begin
      v.hi = a;
      v.lo = 32'hFFFF_FFFF;
    end else begin
      v.hi = a % b;
      v.lo = a / b;
    end
    vecs.push_back(v);
  endfunction

  initial begin
    int nbusy;
    rst_i = 1'b1; start_i = 1'b0; funct_i = 6'h10; rsData_i = '0; rtData_i = '0;

    vecs.push_back('{"multu_max",  6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{"divu_100_7", 6'h1B, 32'd100,       32'd7,         32'd2,         32'd14});
    vecs.push_back('{"divu_by0",   6'h1B, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF});
    vecs.push_back('{"divu_small", 6'h1B, 32'd7,         32'd9,         32'd7,         32'd0});
    vecs.push_back('{"divu_max",   6'h1B, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1});
    vecs.push_back('{"multu_zero", 6'h19, 32'd0,         32'hDEAD_BEEF, 32'd0,         32'd0});
`ifdef MULDIV_SIGNED_EN
    vecs.push_back('{"mult_m3x5",  6'h18, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1});
    vecs.push_back('{"mult_m1xm1", 6'h18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1});
    vecs.push_back('{"div_m7_2",   6'h1A, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{"div_7_m2",   6'h1A, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD});
    vecs.push_back('{"div_ovf",    6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000});
    vecs.push_back('{"div_m7_by0", 6'h1A, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF});
`endif
    for (int i = 0; i < 3; i++) begin
      add_model($sformatf("multu_rnd%0d", i), 6'h19, $urandom, $urandom);
      add_model($sformatf("divu_rnd%0d", i), 6'h1B, $urandom, $urandom_range(1, 32'h0001_FFFF));
    end

    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_hi", hi_o, 32'd0);
    chk("rst_lo", lo_o, 32'd0);
    chk("rst_result", result_o, 32'd0);
    rst_i = 1'b0;
    step();

    start_i = 1'b1; funct_i = 6'h11; rsData_i = 32'h1234_5678;
    step();
    chk("mthi_hi", hi_o, 32'h1234_5678);
    chk("mthi_busy", 32'(busy_o), 32'd0);
    funct_i = 6'h13; rsData_i = 32'hCAFE_F00D;
    step();
    chk("mtlo_lo", lo_o, 32'hCAFE_F00D);
    chk("mtlo_done", 32'(done_o), 32'd0);
    start_i = 1'b0; funct_i = 6'h12;
    #1 chk("mflo_result", result_o, 32'hCAFE_F00D);
    funct_i = 6'h10;
    #1 chk("mfhi_result", result_o, 32'h1234_5678);
    funct_i = 6'h19;
    #1 chk("other_result", result_o, 32'd0);

    start_i = 1'b1; funct_i = 6'h20; rsData_i = 32'd1; rtData_i = 32'd1;
    step();
    chk("unsup_busy", 32'(busy_o), 32'd0);
    chk("unsup_hi", hi_o, 32'h1234_5678);
    chk("unsup_lo", lo_o, 32'hCAFE_F00D);
`ifndef MULDIV_SIGNED_EN
    funct_i = 6'h18; rsData_i = 32'hFFFF_FFFD; rtData_i = 32'd5;
    step();
    chk("mult_off_busy", 32'(busy_o), 32'd0);
    funct_i = 6'h1A;
    step();
    chk("div_off_busy", 32'(busy_o), 32'd0);
    chk("div_off_lo", lo_o, 32'hCAFE_F00D);
`endif
    start_i = 1'b0; funct_i = 6'h00;

    start_i = 1'b1; funct_i = 6'h1B; rsData_i = 32'd1000; rtData_i = 32'd3;
    step();
    start_i = 1'b0; funct_i = 6'h12;
    #1 chk("busy_read_lo", result_o, 32'hCAFE_F00D);
    chk("rstmid_busy_on", 32'(busy_o), 32'd1);
    funct_i = 6'h00;
    repeat (9) step();
    rst_i = 1'b1;
    #1;
    chk("rstmid_busy", 32'(busy_o), 32'd0);
    chk("rstmid_hi", hi_o, 32'd0);
    chk("rstmid_lo", lo_o, 32'd0);
    step();
    step();
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rstmid_no_done", 32'(done_o), 32'd0);
    end
    run_op("rst_then_mul", 6'h19, 32'd6, 32'd7, 32'd0, 32'd42);

    foreach (vecs[i]) begin
      run_op(vecs[i].name, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
    end

    exp_q.push_back('{"b2b_mul", 32'd0, 32'd6});
    start_i = 1'b1; funct_i = 6'h19; rsData_i = 32'd2; rtData_i = 32'd3;
    step();
    start_i = 1'b0; funct_i = 6'h00;
    wait_done("b2b_mul", nbusy);
    chk("b2b_mul_busy_cycles", 32'(nbusy), 32'd32);
    exp_q.push_back('{"b2b_div", 32'd1, 32'd2});
    start_i = 1'b1; funct_i = 6'h1B; rsData_i = 32'd9; rtData_i = 32'd4;
    step();
    start_i = 1'b0; funct_i = 6'h00;
    chk("b2b_rebusy", 32'(busy_o), 32'd1);
    chk("b2b_done_low", 32'(done_o), 32'd0);
    repeat (4) step();
    start_i = 1'b1; funct_i = 6'h11; rsData_i = 32'hDEAD_BEEF;
    step();
    start_i = 1'b0; funct_i = 6'h00;
    chk("midbusy_start_busy", 32'(busy_o), 32'd1);
    chk("midbusy_start_hi", hi_o, 32'd0);
    wait_done("b2b_div", nbusy);
    chk("b2b_div_busy_cycles", 32'(nbusy), 32'd27);
    step();
    chk("b2b_idle_done", 32'(done_o), 32'd0);
    chk("b2b_final_hi", hi_o, 32'd1);

    step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative 32-bit multiply/divide unit for the execute stage, fed by the Decode/Execute pipeline register with rs/rt operand data and the R-type funct field. It owns the architectural HI/LO registers. It performs MULTU/DIVU, and optionally MULT/DIV, over 32 iteration cycles. It raises `busy_o` so pipeline control can stall the front end, and serves MFHI/MFLO reads combinationally.

## Interface
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits.
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `start_i`  in  1  execute stage holds a valid HI/LO-class R-type instruction this cycle.
- `funct_i`  in  6  funct field.
- `rsData_i`  in  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO source).
- `rtData_i`  in  WIDTH  rt operand (multiplier / divisor).
- `busy_o`  out  1  iteration in progress; new HI/LO ops and MFHI/MFLO must stall.
- `done_o`  out  1  one-cycle pulse; HI/LO hold the new result.
- `hi_o`  out  WIDTH  HI register.
- `lo_o`  out  WIDTH  LO register.
- `result_o`  out  WIDTH  MFHI/MFLO read data for the writeback path.

## Operation
- Funct codes:
  - MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13.
  - MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B.
- FSM states are IDLE, MUL, DIV, DONE.
- Acceptance: `start_i` is accepted only in IDLE or DONE. While in MUL or DIV, `start_i` is ignored.
- MTHI / MTLO: HI (or LO) <= `rsData_i` on the accepting edge. The state goes to IDLE and no `done_o` is raised.
- MULTU: enter MUL and latch the operands.
  - Shift-add, 64-bit product, 6-bit counter runs 0..31.
  - After the 32nd iteration: {HI,LO} <= product, then enter DONE.
- DIVU: enter DIV, restoring division, 32 iterations.
  - After the 32nd iteration: LO <= quotient, HI <= remainder, then enter DONE.
- Divide by zero: no trap. Result is LO = 0xFFFFFFFF and HI = dividend, which is the natural restoring result.
- DONE lasts one cycle, then goes to IDLE unless a new op is accepted on that edge.
- Unsupported funct with `start_i` high: ignored; state, HI and LO unchanged.
- `result_o` is combinational:
  - HI when funct_i = 0x10;
  - LO when funct_i = 0x12;
  - 0 otherwise.
  - During `busy_o` it returns the old HI/LO; stalling is the pipeline's responsibility.
- Reset, including mid-operation: state IDLE, counter 0, HI = LO = 0, `busy_o` = 0, `done_o` = 0. Any in-flight result is discarded.

## Timing
- Start accepted at edge 0.
- `busy_o` is high in cycles 1..32 (the MUL/DIV states).
- HI/LO update at edge 32. `done_o` = 1 and `busy_o` = 0 in cycle 33 (the DONE state).
- Total latency: 33 cycles from acceptance to valid HI/LO.
- Back-to-back ops: a start in DONE re-enters MUL/DIV at edge 33 with no idle bubble.
- MTHI/MTLO have a latency of 1 edge; the new value is visible on `hi_o`/`lo_o` the next cycle.
- `busy_o` and `done_o` are registered-state decodes; no combinational path from `start_i`.

## Configuration
- `MULDIV_SIGNED_EN` defined:
  - MULT and DIV are supported.
  - Operands are converted to magnitudes at acceptance; sign fix-up is applied at the final edge.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ; the remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
  - Signed divide by zero gives HI = dividend, LO = 0xFFFFFFFF.
- `MULDIV_SIGNED_EN` undefined: 0x18/0x1A are treated as unsupported functs (ignored, no busy). No sign logic is synthesized.

## Structure
- Package `muldiv_pkg`:
  - funct localparams (`FUNCT_MFHI`..`FUNCT_DIVU`);
  - state enum `muldiv_state_t`;
  - iteration count constant `MULDIV_ITERS` = 32.
- One sub-module is natural: `muldiv_sign_fix`, combinational operand magnitude and result negation, instantiated only under `MULDIV_SIGNED_EN`.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> `busy_o` high for 32 cycles, `done_o` in cycle 33, HI = 0xFFFFFFFE, LO = 0x00000001.
- DIVU 100 / 7 -> LO = 14, HI = 2. Then DIVU 5 / 0 -> LO = 0xFFFFFFFF, HI = 5.
- MTHI 0x12345678, then MFLO after MTLO 0xCAFEF00D -> `hi_o` = 0x12345678 next cycle; `result_o` = 0xCAFEF00D with funct 0x12.
- `MULDIV_SIGNED_EN`:
  - MULT -3 × 5 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
  - DIV -7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - Without the macro, MULT leaves `busy_o` low.
- Assert `rst_i` at iteration 10 of DIVU -> `busy_o` = 0, HI = LO = 0 immediately, no `done_o`. A new MULTU 6 × 7 after release gives LO = 42.
- Start in DONE cycle (MULTU 2 × 3, then immediate DIVU 9 / 4) -> `done_o` pulse, `busy_o` reasserted next cycle, final LO = 2, HI = 1. Also, `start_i` pulsed mid-busy is ignored.
